// File: rtl/rr_interval_timer_pkg.sv
// Shared widths, default timing limits and FSM encoding for the RR-interval timer
// and the blocks that consume its intervals.
package rr_interval_timer_pkg;

  localparam int unsigned RR_W    = 12;
  localparam int unsigned COUNT_W = 16;

  localparam logic [RR_W-1:0] DEF_REFRACT_MS = 12'd250;
  localparam logic [RR_W-1:0] DEF_TIMEOUT_MS = 12'd3000;
  localparam logic [RR_W-1:0] RR_MAX         = {RR_W{1'b1}};

  typedef enum logic [0:0] {
    StIdle,
    StTiming
  } rr_state_e;

  // Saturating beat counter increment.
  function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_interval_timer_if.sv
// Beat input and RR/beat/timeout result bundle of the RR-interval timer.
interface rr_interval_timer_if;
  import rr_interval_timer_pkg::*;

  logic               beat_in;
  logic [RR_W-1:0]    rr_interval_ms;
  logic               new_rr_pulse;
  logic               beat_pulse;
  logic               timeout_pulse;
  logic               signal_lost;
  logic [COUNT_W-1:0] beat_count;

  // Timer side: consumes the raw beat level, produces the interval results.
  modport master (
    input  beat_in,
    output rr_interval_ms,
    output new_rr_pulse,
    output beat_pulse,
    output timeout_pulse,
    output signal_lost,
    output beat_count
  );

  // Environment side: supplies the beat level, observes the results.
  modport slave (
    output beat_in,
    input  rr_interval_ms,
    input  new_rr_pulse,
    input  beat_pulse,
    input  timeout_pulse,
    input  signal_lost,
    input  beat_count
  );

endinterface

// File: rtl/rr_interval_timer_beat_edge_sync.sv
// Two-flop synchroniser for the asynchronous beat level plus a delay flop that turns
// the synchronised level into a single-cycle rise indication.
module rr_interval_timer_beat_edge_sync (
  input  logic clk_div,
  input  logic rst_n,
  input  logic beat_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= beat_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // A level held high yields exactly one rise.
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/rr_interval_timer.sv
// Measures ms ticks between accepted beats, rejects refractory-window edges and flags
// loss of signal when no beat is accepted within the timeout.
module rr_interval_timer
  import rr_interval_timer_pkg::*;
#(
  parameter logic [RR_W-1:0] REFRACT_MS = DEF_REFRACT_MS,
  parameter logic [RR_W-1:0] TIMEOUT_MS = DEF_TIMEOUT_MS
) (
  input  logic                       clk_div,
  input  logic                       rst_n,
  rr_interval_timer_if.master        tmr
);

  logic rise;

  rr_interval_timer_beat_edge_sync u_beat_edge_sync (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .beat_i  (tmr.beat_in),
    .rise_o  (rise)
  );

  rr_state_e          state_q, state_d;
  logic [RR_W-1:0]    elapsed_q, elapsed_d;
  logic [RR_W-1:0]    rr_q, rr_d;
  logic               new_rr_q, new_rr_d;
  logic               beat_q, beat_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               accept;

  always_comb begin
    state_d   = state_q;
    elapsed_d = (elapsed_q == RR_MAX) ? elapsed_q : elapsed_q + RR_W'(1);
    rr_d      = rr_q;
    new_rr_d  = 1'b0;
    beat_d    = 1'b0;
    timeout_d = 1'b0;
    count_d   = count_q;
    accept    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // First beat after IDLE only establishes the RR reference.
        if (rise) begin
          accept  = 1'b1;
          state_d = StTiming;
        end
      end
      StTiming: begin
        // A beat landing on the timeout cycle wins over the timeout.
        if (rise && (elapsed_q >= REFRACT_MS)) begin
          accept   = 1'b1;
          rr_d     = elapsed_q;
          new_rr_d = 1'b1;
        end else if (elapsed_q == TIMEOUT_MS) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      beat_d    = 1'b1;
      elapsed_d = RR_W'(1);
      count_d   = sat_inc_count(count_q);
    end
  end

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      elapsed_q <= '0;
      rr_q      <= '0;
      new_rr_q  <= 1'b0;
      beat_q    <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      rr_q      <= rr_d;
      new_rr_q  <= new_rr_d;
      beat_q    <= beat_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign tmr.rr_interval_ms = rr_q;
  assign tmr.new_rr_pulse   = new_rr_q;
  assign tmr.beat_pulse     = beat_q;
  assign tmr.timeout_pulse  = timeout_q;
  assign tmr.signal_lost    = (state_q == StIdle);
  assign tmr.beat_count     = count_q;

endmodule

// File: tb/tb_rr_interval_timer.sv
// Bench for rr_interval_timer: directed scenarios plus random beat trains, checked every
// cycle against a beat-timestamp reference model and pinned by literal expectations.
module tb_rr_interval_timer;

  localparam int RefractMs = 250;
  localparam int TimeoutMs = 3000;

  logic clk_div = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk_div = ~clk_div;

  rr_interval_timer_if tmr ();

  rr_interval_timer #(
    .REFRACT_MS (12'd250),
    .TIMEOUT_MS (12'd3000)
  ) dut (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .tmr     (tmr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats are timestamped by edge index; the RR is the difference
  // between the current and the last accepted timestamp.
  int          cyc = 0;
  int          last_acc = 0;
  bit          m_idle = 1'b1;
  bit          m_valid = 1'b0;
  logic        h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic [11:0] e_rr = '0;
  logic [15:0] e_cnt = '0;
  logic        e_beat = 1'b0, e_nrr = 1'b0, e_to = 1'b0, e_lost = 1'b1;

  always @(posedge clk_div) begin
    int  cand;
    bit  rise;
    cyc++;
    if (!rst_n) begin
      m_idle = 1'b1;
      {h0, h1, h2} = 3'b000;
      e_rr = '0;
      e_cnt = '0;
      {e_beat, e_nrr, e_to} = 3'b000;
      e_lost = 1'b1;
      m_valid = 1'b1;
    end else begin
      // Input edge reaches the decision two samples after it is captured.
      rise = h1 && !h2;
      h2 = h1;
      h1 = h0;
      h0 = tmr.beat_in;
      cand = cyc - last_acc;
      if (cand > 4095) cand = 4095;
      {e_beat, e_nrr, e_to} = 3'b000;
      if (m_idle) begin
        if (rise) begin
          e_beat = 1'b1;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
          last_acc = cyc;
          m_idle = 1'b0;
        end
      end else if (rise && cand >= RefractMs) begin
        e_beat = 1'b1;
        e_nrr = 1'b1;
        e_rr = 12'(cand);
        if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        last_acc = cyc;
      end else if (cand == TimeoutMs) begin
        e_to = 1'b1;
        m_idle = 1'b1;
      end
      e_lost = m_idle;
    end
  end

  int beat_seen = 0, nrr_seen = 0, to_seen = 0;

  always @(negedge clk_div) begin
    if (tmr.beat_pulse === 1'b1) beat_seen++;
    if (tmr.new_rr_pulse === 1'b1) nrr_seen++;
    if (tmr.timeout_pulse === 1'b1) to_seen++;
    if (m_valid) begin
      chk("rr_interval_ms", 32'(tmr.rr_interval_ms), 32'(e_rr));
      chk("new_rr_pulse", 32'(tmr.new_rr_pulse), 32'(e_nrr));
      chk("beat_pulse", 32'(tmr.beat_pulse), 32'(e_beat));
      chk("timeout_pulse", 32'(tmr.timeout_pulse), 32'(e_to));
      chk("signal_lost", 32'(tmr.signal_lost), 32'(e_lost));
      chk("beat_count", 32'(tmr.beat_count), 32'(e_cnt));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_div);
      #2;
    end
  endtask

  // Raise beat_in for w cycles, then hold it low so the next call's rise is gap cycles later.
  task automatic beat_gap(input int gap, input int w);
    tmr.beat_in = 1'b1;
    step(w);
    tmr.beat_in = 1'b0;
    step(gap - w);
  endtask

  initial begin
    int gap, w, sel;
    tmr.beat_in = 1'b0;

    // Reset while the beat input toggles.
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tmr.beat_in = ~tmr.beat_in;
      step(1);
    end
    tmr.beat_in = 1'b0;
    chk("reset signal_lost", 32'(tmr.signal_lost), 32'd1);
    chk("reset beat_count", 32'(tmr.beat_count), 32'd0);
    chk("reset rr", 32'(tmr.rr_interval_ms), 32'd0);
    chk("reset strobes", 32'(beat_seen + nrr_seen + to_seen), 32'd0);
    rst_n = 1'b1;
    step(5);

    // Three beats 800 apart: first establishes the reference only.
    for (int i = 0; i < 3; i++) beat_gap(800, 4);
    chk("train beat_seen", 32'(beat_seen), 32'd3);
    chk("train nrr_seen", 32'(nrr_seen), 32'd2);
    chk("train rr", 32'(tmr.rr_interval_ms), 32'd800);
    chk("train beat_count", 32'(tmr.beat_count), 32'd3);

    // Glitch 100 after a beat is dropped; a rise exactly at the refractory limit counts.
    beat_gap(100, 5);
    beat_gap(700, 5);
    beat_gap(250, 5);
    beat_gap(3010, 5);
    chk("refract rr", 32'(tmr.rr_interval_ms), 32'd250);
    chk("refract nrr_seen", 32'(nrr_seen), 32'd5);
    chk("refract beat_count", 32'(tmr.beat_count), 32'd6);
    chk("timeout to_seen", 32'(to_seen), 32'd1);
    chk("timeout signal_lost", 32'(tmr.signal_lost), 32'd1);

    // First beat after timeout gives no RR; the next lands exactly on the timeout count.
    beat_gap(3000, 5);
    chk("idle beat nrr_seen", 32'(nrr_seen), 32'd5);
    chk("idle beat signal_lost", 32'(tmr.signal_lost), 32'd0);
    beat_gap(300, 5);
    chk("edge rr", 32'(tmr.rr_interval_ms), 32'd3000);
    chk("edge to_seen", 32'(to_seen), 32'd1);
    chk("edge signal_lost", 32'(tmr.signal_lost), 32'd0);

    // Reset 400 cycles into an interval.
    beat_gap(400, 5);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(5);
    beat_gap(600, 5);
    beat_gap(600, 5);
    chk("post-reset beat_count", 32'(tmr.beat_count), 32'd2);
    chk("post-reset rr", 32'(tmr.rr_interval_ms), 32'd600);
    chk("post-reset nrr_seen", 32'(nrr_seen), 32'd8);

    // Random beat trains around the refractory and timeout boundaries.
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       gap = int'($urandom_range(2, 260));
        1:       gap = int'($urandom_range(240, 260));
        2:       gap = int'($urandom_range(2990, 3010));
        default: gap = int'($urandom_range(300, 1200));
      endcase
      w = int'($urandom_range(1, (gap - 1 < 20) ? gap - 1 : 20));
      beat_gap(gap, w);
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
    end
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
